ripple_add_sub_seq: RTL and testbench

Nibble-serial wide adder/subtractor controller. It time-shares one internal 4-bit ripple add/sub slice (the slice has carry-in) over WORDS cycles, processing the LSB nibble first, to compute a 4*WORDS-bit A+B or A-B. Clients use a START/BUSY/DONE handshake. It sits between a client and the combinational add/sub datapath, trading latency for area.

---
 rtl/ripple_add_sub_seq.sv | 95 +++++++++
 tb/tb_ripple_add_sub_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ripple_add_sub_seq.sv
// Nibble-serial add/sub: one 4-bit ripple slice is reused for WORDS cycles, LSB nibble first.
// START/BUSY/DONE handshake. Results update only on completion.
module ripple_add_sub_seq #(
  parameter int WORDS = 4,
  localparam int N = 4*WORDS
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic         Choice,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         BUSY,
  output logic         DONE,
  output logic [N-1:0] RESULT,
  output logic         CARRY,
  output logic         OVERFLOW
);
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS-1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t                  r_state, w_next;
  logic [WORDS-1:0][3:0]   r_a, r_b, r_acc, w_res;
  logic                    r_sub, r_c;
  logic [IW-1:0]           r_idx;
  logic [4:0]              w_sum;
  logic                    w_load, w_last;

  // START is honoured in IDLE and FIN, never while nibbles are in flight
  assign w_load = START && (r_state != S_RUN);
  assign w_last = (r_state == S_RUN) && (r_idx == LAST);

  assign w_sum = {1'b0, r_a[r_idx]} + {1'b0, r_b[r_idx] ^ {4{r_sub}}} + {4'b0, r_c};

  always_comb begin
    w_res        = r_acc;
    w_res[r_idx] = w_sum[3:0];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    BUSY   = 1'b0;
    DONE   = 1'b0;
    case (r_state)
      S_IDLE: if (START) w_next = S_RUN;
      S_RUN: begin
        BUSY = 1'b1;
        if (w_last) w_next = S_FIN;
      end
      S_FIN: begin
        DONE   = 1'b1;
        w_next = START ? S_RUN : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_sub    <= 1'b0;
      r_c      <= 1'b0;
      r_idx    <= '0;
      RESULT   <= '0;
      CARRY    <= 1'b0;
      OVERFLOW <= 1'b0;
    end else if (w_load) begin
      r_a   <= A;
      r_b   <= B;
      r_sub <= Choice;
      r_c   <= Choice;
      r_idx <= '0;
    end else if (r_state == S_RUN) begin
      r_acc[r_idx] <= w_sum[3:0];
      r_c          <= w_sum[4];
      r_idx        <= r_idx + 1'b1;
      if (w_last) begin
        RESULT   <= w_res;
        CARRY    <= w_sum[4];
        // signed overflow: both inputs agree in sign and the sum disagrees
        OVERFLOW <= (r_a[WORDS-1][3] ^ w_sum[3]) &
                    ((r_b[WORDS-1][3] ^ r_sub) ^ w_sum[3]);
      end
    end
  end
endmodule

// File: tb/tb_ripple_add_sub_seq.sv
// Bench for ripple_add_sub_seq: full-width arithmetic reference model, per-cycle compare,
// directed literal cases plus randomized traffic.
module tb_ripple_add_sub_seq;
  localparam int WORDS = 4;
  localparam int N = 4*WORDS;

  logic         CLK, RST, START, Choice;
  logic [N-1:0] A, B;
  logic         BUSY, DONE, CARRY, OVERFLOW;
  logic [N-1:0] RESULT;

  int n_cmp = 0;
  int n_bad = 0;

  ripple_add_sub_seq #(.WORDS(WORDS)) dut (
    .CLK(CLK), .RST(RST), .START(START), .Choice(Choice), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .CARRY(CARRY), .OVERFLOW(OVERFLOW)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // {carry, overflow, result} from plain integer arithmetic
  function automatic logic [N+1:0] ref_op(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic sub);
    longint ua, ub, sa, sb, r, s;
    logic c, v;
    ua = longint'(a);
    ub = longint'(b);
    sa = (a[N-1]) ? ua - (longint'(1) << N) : ua;
    sb = (b[N-1]) ? ub - (longint'(1) << N) : ub;
    if (sub) begin
      r = ua - ub; c = (ua >= ub); s = sa - sb;
    end else begin
      r = ua + ub; c = (r >= (longint'(1) << N)); s = sa + sb;
    end
    v = (s > ((longint'(1) << (N-1)) - 1)) || (s < -(longint'(1) << (N-1)));
    return {c, v, r[N-1:0]};
  endfunction

  // Behavioural timing model: accept when idle, result WORDS edges later, DONE one cycle
  int           m_cnt = 0;
  logic         m_busy = 0, m_done = 0, m_c = 0, m_v = 0;
  logic [N-1:0] m_res = '0;
  logic [N+1:0] m_pend = '0;

  initial forever begin
    @(posedge CLK or posedge RST);
    if (RST) begin
      m_cnt = 0; m_busy = 0; m_done = 0; m_res = '0; m_c = 0; m_v = 0;
    end else begin
      m_done = 0;
      if (m_cnt == 0) begin
        if (START) begin
          m_pend = ref_op(A, B, Choice);
          m_cnt  = WORDS;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          {m_c, m_v, m_res} = m_pend;
          m_done = 1;
        end
      end
      m_busy = (m_cnt > 0);
    end
  end

  initial forever begin
    @(negedge CLK);
    chk("busy", 32'(BUSY), 32'(m_busy));
    chk("done", 32'(DONE), 32'(m_done));
    chk("result", 32'(RESULT), 32'(m_res));
    chk("carry", 32'(CARRY), 32'(m_c));
    chk("overflow", 32'(OVERFLOW), 32'(m_v));
  end

  // Drive a request at the current (negedge) time
  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b, input logic ch);
    A = a; B = b; Choice = ch; START = 1'b1;
  endtask

  // Follow an accepted op to DONE; disturbs inputs and pulses START mid-run
  task automatic finish(input string name, input logic [N-1:0] er, input logic ec,
                        input logic ev);
    int n;
    n = 0;
    while (1) begin
      @(posedge CLK);
      n++;
      @(negedge CLK);
      if (n == 1) begin
        START = 1'b0; A = ~A; B = B + 16'h1234; Choice = ~Choice;
      end
      if (n == 2) begin
        START = 1'b1; A = 16'hDEAD; B = 16'hBEEF;
      end
      if (n == 3) START = 1'b0;
      if (DONE) break;
      if (n >= 20) begin
        chk({name, "_timeout"}, 32'(n), 32'(WORDS+1));
        return;
      end
    end
    chk({name, "_lat"}, 32'(n), 32'(WORDS+1));
    chk({name, "_res"}, 32'(RESULT), 32'(er));
    chk({name, "_c"}, 32'(CARRY), 32'(ec));
    chk({name, "_v"}, 32'(OVERFLOW), 32'(ev));
  endtask

  logic [N-1:0] pick[5] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001};

  initial begin
    RST = 1'b1; START = 1'b0; A = '0; B = '0; Choice = 1'b0;
    #23;
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_done", 32'(DONE), 0);
    chk("rst_result", 32'(RESULT), 0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Each launch after the first happens in the DONE cycle: back-to-back
    launch(16'h0006, 16'h0005, 1'b0); finish("add6_5", 16'h000B, 0, 0);
    launch(16'h0006, 16'h0005, 1'b1); finish("sub6_5", 16'h0001, 1, 0);
    launch(16'h0004, 16'h0005, 1'b1); finish("sub4_5", 16'hFFFF, 0, 0);
    launch(16'h00F0, 16'h0010, 1'b0); finish("nib_carry", 16'h0100, 0, 0);
    launch(16'hFFFF, 16'h0001, 1'b0); finish("wrap", 16'h0000, 1, 0);
    launch(16'h7FFF, 16'h0001, 1'b0); finish("ovf_add", 16'h8000, 0, 1);
    launch(16'h8000, 16'h0001, 1'b1); finish("ovf_sub", 16'h7FFF, 1, 1);

    // Asynchronous reset after two RUN cycles
    launch(16'h1234, 16'h1111, 1'b0);
    @(posedge CLK);
    @(negedge CLK); START = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("abort_busy", 32'(BUSY), 0);
    chk("abort_done", 32'(DONE), 0);
    chk("abort_result", 32'(RESULT), 0);
    chk("abort_c", 32'(CARRY), 0);
    chk("abort_v", 32'(OVERFLOW), 0);
    @(negedge CLK); RST = 1'b0;
    @(negedge CLK);
    launch(16'h1234, 16'h1111, 1'b0); finish("after_rst", 16'h2345, 0, 0);
    @(negedge CLK); START = 1'b0;

    // Random traffic: inputs churn every cycle, START at random
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      START  = ($urandom_range(0, 2) == 0);
      A      = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : N'($urandom);
      B      = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : N'($urandom);
      Choice = 1'($urandom);
    end
    @(negedge CLK); START = 1'b0;
    repeat (WORDS + 3) @(negedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
